// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader and the ALU it feeds.
//   - ALU op-code constants OP_AND..OP_SLL (000..111)
//   - FSM state encoding S_LOAD_A..S_DONE (state_t)
//   - num_bytes(): bytes per operand, DATA_W/BYTE_W
package alu_operand_loader_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_SLL = 3'b111;

   typedef enum logic [2:0] {
      S_LOAD_A = 3'd0,
      S_LOAD_B = 3'd1,
      S_READY  = 3'd2,
      S_EXEC   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   function automatic int num_bytes(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

endpackage

// File: rtl/alu_operand_loader_shift_reg.sv
// operand_shift_reg: one ALU operand assembled a byte at a time, MSB byte first.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (q -> 0)
//   clr         clear; together with shift_en the register restarts as {0, din}
//   shift_en    q <= {q[DATA_W-BYTE_W-1:0], din}
//   din         byte from the switch bus
//   q           assembled operand
module operand_shift_reg #(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              shift_en,
   input  logic [BYTE_W-1:0] din,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         // clr+shift_en starts a fresh operand whose first byte is din
         q <= shift_en ? DATA_W'(din) : '0;
      end else if (shift_en) begin
         q <= {q[DATA_W-BYTE_W-1:0], din};
      end
   end

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: operand/control stage in front of a combinational ALU.
// Builds A and B from byte-wide switch input (one byte per load_pulse), latches
// the op code on exec_pulse, holds the ALU inputs for one settle cycle (S_EXEC)
// and captures F/ZF/OF into result registers.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sw_data, sw_op      switch byte and op code
//   load_pulse          take sw_data into the operand being loaded
//   exec_pulse          take sw_op and execute
//   A, B, ALU_OP        registered ALU inputs
//   alu_F/ZF/OF         ALU outputs
//   result, res_ZF/OF   captured ALU outputs
//   done                result/flags valid for current A/B/ALU_OP
//   state_o             FSM state for LEDs
//   byte_idx            bytes of the current operand already taken
// Build option: define ALU_LOADER_AUTOEXEC_EN to execute straight after the last
// B byte (sw_op sampled on that edge) instead of waiting in S_READY.
module alu_operand_loader
   import alu_operand_loader_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] sw_data,
   input  logic [2:0]        sw_op,
   input  logic              load_pulse,
   input  logic              exec_pulse,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [2:0]        ALU_OP,
   input  logic [DATA_W-1:0] alu_F,
   input  logic              alu_ZF,
   input  logic              alu_OF,
   output logic [DATA_W-1:0] result,
   output logic              res_ZF,
   output logic              res_OF,
   output logic              done,
   output logic [2:0]        state_o,
   output logic [1:0]        byte_idx
);

   localparam int         NUM_BYTES = num_bytes(DATA_W, BYTE_W);
   localparam logic [1:0] LAST_IDX  = 2'(NUM_BYTES - 1);

   state_t state, state_n;
   logic   shift_a, shift_b, clr_ops;
   logic   take_op, capture, done_clr, idx_inc, idx_set1;
   logic   last_byte;

   assign last_byte = (byte_idx == LAST_IDX);
   assign state_o   = state;

   operand_shift_reg #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_reg_a (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_ops),
      .shift_en (shift_a),
      .din      (sw_data),
      .q        (A)
   );

   operand_shift_reg #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_reg_b (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_ops),
      .shift_en (shift_b),
      .din      (sw_data),
      .q        (B)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_LOAD_A;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      shift_a  = 1'b0;
      shift_b  = 1'b0;
      clr_ops  = 1'b0;
      take_op  = 1'b0;
      capture  = 1'b0;
      done_clr = 1'b0;
      idx_inc  = 1'b0;
      idx_set1 = 1'b0;
      case (state)
         S_LOAD_A: begin
            if (load_pulse) begin
               shift_a = 1'b1;
               idx_inc = 1'b1;
               if (last_byte) state_n = S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            if (load_pulse) begin
               shift_b = 1'b1;
               idx_inc = 1'b1;
               if (last_byte) begin
`ifdef ALU_LOADER_AUTOEXEC_EN
                  take_op = 1'b1;
                  state_n = S_EXEC;
`else
                  state_n = S_READY;
`endif
               end
            end
         end
         S_READY: begin
            if (exec_pulse) begin
               take_op = 1'b1;
               state_n = S_EXEC;
            end
         end
         // One idle cycle lets the ALU settle on the registered inputs.
         S_EXEC: begin
            capture = 1'b1;
            state_n = S_DONE;
         end
         S_DONE: begin
            // Load has priority: a new A starts with this byte, B is cleared.
            if (load_pulse) begin
               clr_ops  = 1'b1;
               shift_a  = 1'b1;
               idx_set1 = 1'b1;
               done_clr = 1'b1;
               state_n  = S_LOAD_A;
            end else if (exec_pulse) begin
               take_op  = 1'b1;
               done_clr = 1'b1;
               state_n  = S_EXEC;
            end
         end
         default: state_n = S_LOAD_A;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ALU_OP   <= OP_AND;
         result   <= '0;
         res_ZF   <= 1'b0;
         res_OF   <= 1'b0;
         done     <= 1'b0;
         byte_idx <= 2'd0;
      end else begin
         if (take_op) ALU_OP <= sw_op;
         if (capture) begin
            result <= alu_F;
            res_ZF <= alu_ZF;
            res_OF <= alu_OF;
         end
         if (capture)       done <= 1'b1;
         else if (done_clr) done <= 1'b0;
         if (idx_set1)     byte_idx <= 2'd1;
         else if (idx_inc) byte_idx <= last_byte ? 2'd0 : byte_idx + 2'd1;
      end
   end

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;
   import alu_operand_loader_pkg::*;

   localparam int DW = 32;
   localparam int BW = 8;
   localparam int NB = DW / BW;

   localparam int M_LA = 0, M_LB = 1, M_RD = 2, M_EX = 3, M_DN = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [BW-1:0] sw_data = '0;
   logic [2:0]    sw_op = '0;
   logic          load_pulse = 1'b0;
   logic          exec_pulse = 1'b0;
   logic [DW-1:0] A, B, alu_F, result;
   logic [2:0]    ALU_OP, state_o;
   logic          alu_ZF, alu_OF, res_ZF, res_OF, done;
   logic [1:0]    byte_idx;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // Reference ALU: {OF, ZF, F}
   function automatic logic [DW+1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [2:0] op);
      logic [DW-1:0] f;
      logic of;
      of = 1'b0;
      case (op)
         OP_AND: f = a & b;
         OP_OR:  f = a | b;
         OP_XOR: f = a ^ b;
         OP_NOR: f = ~(a | b);
         OP_ADD: begin f = a + b; of = (a[DW-1] == b[DW-1]) && (f[DW-1] != a[DW-1]); end
         OP_SUB: begin f = a - b; of = (a[DW-1] != b[DW-1]) && (f[DW-1] != a[DW-1]); end
         OP_SLT: f = DW'($signed(a) < $signed(b));
         OP_SLL: f = b << a[4:0];
         default: f = '0;
      endcase
      return {of, (f == '0), f};
   endfunction

   assign {alu_OF, alu_ZF, alu_F} = alu(A, B, ALU_OP);

   alu_operand_loader #(.DATA_W(DW), .BYTE_W(BW)) dut (
      .clk(clk), .rst(rst), .sw_data(sw_data), .sw_op(sw_op),
      .load_pulse(load_pulse), .exec_pulse(exec_pulse),
      .A(A), .B(B), .ALU_OP(ALU_OP),
      .alu_F(alu_F), .alu_ZF(alu_ZF), .alu_OF(alu_OF),
      .result(result), .res_ZF(res_ZF), .res_OF(res_OF),
      .done(done), .state_o(state_o), .byte_idx(byte_idx)
   );

   // Behavioural model: operands as integers, shifted a byte at a time.
   int            m_st;
   logic [DW-1:0] m_a, m_b, m_res;
   logic [2:0]    m_op;
   logic          m_zf, m_of, m_done;
   int            m_idx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st <= M_LA; m_a <= '0; m_b <= '0; m_op <= 3'b000; m_res <= '0;
         m_zf <= 1'b0; m_of <= 1'b0; m_done <= 1'b0; m_idx <= 0;
      end else begin
         case (m_st)
            M_LA: if (load_pulse) begin
               m_a   <= (m_a << BW) | DW'(sw_data);
               m_idx <= (m_idx + 1) % NB;
               if (m_idx == NB - 1) m_st <= M_LB;
            end
            M_LB: if (load_pulse) begin
               m_b   <= (m_b << BW) | DW'(sw_data);
               m_idx <= (m_idx + 1) % NB;
               if (m_idx == NB - 1) begin
`ifdef ALU_LOADER_AUTOEXEC_EN
                  m_op <= sw_op;
                  m_st <= M_EX;
`else
                  m_st <= M_RD;
`endif
               end
            end
            M_RD: if (exec_pulse) begin
               m_op <= sw_op;
               m_st <= M_EX;
            end
            M_EX: begin
               {m_of, m_zf, m_res} <= alu(m_a, m_b, m_op);
               m_done <= 1'b1;
               m_st   <= M_DN;
            end
            default: begin
               if (load_pulse) begin
                  m_a <= DW'(sw_data); m_b <= '0; m_idx <= 1; m_done <= 1'b0; m_st <= M_LA;
               end else if (exec_pulse) begin
                  m_op <= sw_op; m_done <= 1'b0; m_st <= M_EX;
               end
            end
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("state",    64'(state_o),  64'(m_st));
         chk("A",        64'(A),        64'(m_a));
         chk("B",        64'(B),        64'(m_b));
         chk("ALU_OP",   64'(ALU_OP),   64'(m_op));
         chk("result",   64'(result),   64'(m_res));
         chk("res_ZF",   64'(res_ZF),   64'(m_zf));
         chk("res_OF",   64'(res_OF),   64'(m_of));
         chk("done",     64'(done),     64'(m_done));
         chk("byte_idx", 64'(byte_idx), 64'(m_idx));
      end
   end

   // Sets inputs 2 time units after a rising edge; they are sampled at the next one.
   task automatic tick(input logic ld, input logic ex, input logic [7:0] d, input logic [2:0] op);
      @(posedge clk); #2;
      load_pulse = ld; exec_pulse = ex; sw_data = d; sw_op = op;
   endtask

   task automatic load_word(input logic [31:0] w, input logic [2:0] op);
      logic [31:0] t;
      t = w;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, t[31:24], op);
         t = t << 8;
      end
   endtask

   // Exec strobe, then literal check 2 edges after it was sampled-window opened.
   task automatic exec_and_check(input logic [2:0] op, input logic [31:0] exp_f,
                                 input logic exp_zf, input logic exp_of, input string tag);
      tick(1'b0, 1'b1, 8'h00, op);
      tick(1'b0, 1'b0, 8'h00, op);
      #1 chk({tag, "_done_low"}, 64'(done), 64'(0));
      tick(1'b0, 1'b0, 8'h00, op);
      #1;
      chk({tag, "_done"}, 64'(done), 64'(1));
      chk({tag, "_F"}, 64'(result), 64'(exp_f));
      chk({tag, "_ZF"}, 64'(res_ZF), 64'(exp_zf));
      chk({tag, "_OF"}, 64'(res_OF), 64'(exp_of));
   endtask

   initial begin
      // 1: reset
      #1 rst = 1'b1;
      #3 rst = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_A", 64'(A), 64'(0));
      chk("rst_B", 64'(B), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_op", 64'(ALU_OP), 64'(0));
      chk("rst_state", 64'(state_o), 64'(M_LA));
      chk("rst_done", 64'(done), 64'(0));

      // 2: add
      load_word(32'h12345678, OP_ADD);
      load_word(32'h33332222, OP_ADD);
      tick(1'b0, 1'b0, 8'h00, OP_ADD);
      #1;
      chk("t2_A", 64'(A), 64'h12345678);
      chk("t2_B", 64'(B), 64'h33332222);
      exec_and_check(OP_ADD, 32'h4567789A, 1'b0, 1'b0, "t2");

      // 3: re-run with AND
      exec_and_check(OP_AND, 32'h12300220, 1'b0, 1'b0, "t3");

      // 4: overflow and zero
      load_word(32'h7FFFFFFF, OP_ADD);
      load_word(32'h7FFFFFFF, OP_ADD);
      exec_and_check(OP_ADD, 32'hFFFFFFFE, 1'b0, 1'b1, "t4add");
      exec_and_check(OP_SUB, 32'h00000000, 1'b1, 1'b0, "t4sub");

      // 5: reset mid-load
      tick(1'b1, 1'b0, 8'h11, OP_ADD);
      tick(1'b1, 1'b0, 8'h22, OP_ADD);
      tick(1'b0, 1'b0, 8'h00, OP_ADD);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("t5_A", 64'(A), 64'(0));
      chk("t5_idx", 64'(byte_idx), 64'(0));
      chk("t5_state", 64'(state_o), 64'(M_LA));
      #1 rst = 1'b0;
      load_word(32'h01020304, OP_ADD);
      load_word(32'h10203040, OP_ADD);
      exec_and_check(OP_ADD, 32'h11223344, 1'b0, 1'b0, "t5");

      // 6: load and exec together in S_DONE
      tick(1'b1, 1'b1, 8'hAB, OP_SLL);
      tick(1'b0, 1'b0, 8'h00, OP_SLL);
      #1;
      chk("t6_state", 64'(state_o), 64'(M_LA));
      chk("t6_A", 64'(A), 64'h000000AB);
      chk("t6_B", 64'(B), 64'(0));
      chk("t6_idx", 64'(byte_idx), 64'(1));
      chk("t6_op", 64'(ALU_OP), 64'(OP_ADD));
      chk("t6_done", 64'(done), 64'(0));

      // Randomized phase, checked every cycle against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            @(posedge clk); #2;
            rst = 1'b1; load_pulse = 1'b0; exec_pulse = 1'b0;
            #2 rst = 1'b0;
         end else begin
            tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), 3'($urandom));
         end
      end
      tick(1'b0, 1'b0, 8'h00, 3'b000);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
